// File: rtl/fifo_fill_pkg.sv
// Shared types and constants for the FIFO fill controller.
//   state_e       : controller FSM state encoding
//   MODE_CONST/INCR: data source select values
//   marks_legal() : elaboration-time watermark sanity check
package fifo_fill_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StWait  = 2'd2
  } state_e;

  localparam logic MODE_CONST = 1'b0;
  localparam logic MODE_INCR  = 1'b1;

  // Watermarks must satisfy 0 <= low < high <= max occupancy (2^cnt_w - 1).
  function automatic bit marks_legal(input int unsigned high_mark,
                                     input int unsigned low_mark,
                                     input int unsigned cnt_w);
    int unsigned max_words;
    max_words = (32'd1 << cnt_w) - 32'd1;
    return (low_mark < high_mark) && (high_mark <= max_words);
  endfunction

endpackage

// File: rtl/fifo_fill_if.sv
// Write-side FIFO bus between the fill controller and the FIFO.
//   wr_en      : write strobe (controller -> FIFO)
//   fifo_data  : write data, valid while wr_en = 1 (controller -> FIFO)
//   fifo_words : current FIFO occupancy (FIFO -> controller)
//   fifo_full  : FIFO full flag, hard write gate (FIFO -> controller)
// master = controller side, slave = FIFO side.
interface fifo_fill_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
);

  logic              wr_en;
  logic [DATA_W-1:0] fifo_data;
  logic [CNT_W-1:0]  fifo_words;
  logic              fifo_full;

  modport master (
    output wr_en,
    output fifo_data,
    input  fifo_words,
    input  fifo_full
  );

  modport slave (
    input  wr_en,
    input  fifo_data,
    output fifo_words,
    output fifo_full
  );

endinterface

// File: rtl/fifo_fill_datagen.sv
// Write-data generator for the FIFO fill controller.
// Holds the data register presented on the FIFO write bus.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wr_en_i       : a write is accepted this cycle (advances INCR data)
//   mode_i        : MODE_CONST holds PATTERN, MODE_INCR counts per write
//   dreg_o        : current data register value
module fifo_fill_datagen
  import fifo_fill_pkg::*;
#(
  parameter int unsigned       DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = 8'hAA
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic              mode_i,
  output logic [DATA_W-1:0] dreg_o
);

  logic [DATA_W-1:0] dreg_q, dreg_d;
  logic              mode_q, mode_d;
  logic              mode_changed;

  assign mode_changed = (mode_i != mode_q);

  always_comb begin
    mode_d = mode_i;
    dreg_d = dreg_q;
    if (mode_changed && (dreg_q != PATTERN)) begin
      // Any mode switch restarts the sequence from PATTERN; the write (if any)
      // in this cycle still used the old value.
      dreg_d = PATTERN;
    end else if (mode_i == MODE_CONST) begin
      dreg_d = PATTERN;
    end else if (wr_en_i) begin
      // Natural wrap modulo 2^DATA_W.
      dreg_d = dreg_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dreg_q <= PATTERN;
      mode_q <= MODE_CONST;
    end else begin
      dreg_q <= dreg_d;
      mode_q <= mode_d;
    end
  end

  assign dreg_o = dreg_q;

endmodule

// File: rtl/fifo_fill_ctrl.sv
// FIFO producer controller with watermark hysteresis.
// Writes into a downstream FIFO until occupancy reaches HIGH_MARK, then waits
// until it drains to LOW_MARK before writing again.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   enable   : run request; low forces IDLE from any state
//   mode     : data source, MODE_CONST or MODE_INCR
//   fifo     : write-side FIFO bus (wr_en/fifo_data out, fifo_words/fifo_full in)
//   wr_count : accepted writes since reset, wraps modulo 2^WCNT_W
//   hi_evt   : one-cycle pulse after a WRITE -> WAIT transition
module fifo_fill_ctrl
  import fifo_fill_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       CNT_W     = 4,
  parameter int unsigned       HIGH_MARK = 5,
  parameter int unsigned       LOW_MARK  = 2,
  parameter logic [DATA_W-1:0] PATTERN   = 8'hAA,
  parameter int unsigned       WCNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              mode,
  fifo_fill_if.master       fifo,
  output logic [WCNT_W-1:0] wr_count,
  output logic              hi_evt
);

  if (!marks_legal(HIGH_MARK, LOW_MARK, CNT_W)) begin : g_bad_marks
    $error("fifo_fill_ctrl: need 0 <= LOW_MARK < HIGH_MARK <= 2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] HighMark = CNT_W'(HIGH_MARK);
  localparam logic [CNT_W-1:0] LowMark  = CNT_W'(LOW_MARK);

  state_e            state_q, state_d;
  logic              hi_evt_q, hi_evt_d;
  logic [WCNT_W-1:0] wr_count_q, wr_count_d;
  logic              wr_en;
  logic              at_high;
  logic              at_low;
  logic [DATA_W-1:0] dreg;

  // >= rather than == so an occupancy that overshoots the mark still stops us.
  assign at_high = (fifo.fifo_words >= HighMark);
  assign at_low  = (fifo.fifo_words <= LowMark);

  // Occupancy lags writes by a cycle; the at_high term blocks the write in
  // the cycle the count first reports HIGH_MARK.
  assign wr_en = (state_q == StWrite) && !fifo.fifo_full && !at_high;

  always_comb begin
    state_d  = state_q;
    hi_evt_d = 1'b0;
    if (!enable) begin
      // Disable wins over the watermark: no hi_evt when both coincide.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StWrite;
        StWrite: begin
          if (at_high) begin
            state_d  = StWait;
            hi_evt_d = 1'b1;
          end
        end
        StWait: begin
          if (at_low) begin
            state_d = StWrite;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_en) begin
      wr_count_d = wr_count_q + WCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hi_evt_q   <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      hi_evt_q   <= hi_evt_d;
      wr_count_q <= wr_count_d;
    end
  end

  fifo_fill_datagen #(
    .DATA_W  (DATA_W),
    .PATTERN (PATTERN)
  ) u_datagen (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .wr_en_i (wr_en),
    .mode_i  (mode),
    .dreg_o  (dreg)
  );

  assign fifo.wr_en     = wr_en;
  assign fifo.fifo_data = dreg;
  assign wr_count       = wr_count_q;
  assign hi_evt         = hi_evt_q;

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Self-checking bench for fifo_fill_ctrl. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge. Expected write data is pushed
// to exp_q when a write is expected and popped when wr_en is seen.
module tb_fifo_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] wr_count;
  logic        hi_evt;

  fifo_fill_if #(.DATA_W(8), .CNT_W(4)) ff ();

  fifo_fill_ctrl #(
    .DATA_W    (8),
    .CNT_W     (4),
    .HIGH_MARK (5),
    .LOW_MARK  (2),
    .PATTERN   (8'hAA),
    .WCNT_W    (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .mode     (mode),
    .fifo     (ff),
    .wr_count (wr_count),
    .hi_evt   (hi_evt)
  );

  always #5 clk = ~clk;

  logic [7:0]  exp_q[$];
  logic [15:0] exp_wc = '0;
  logic [7:0]  got;
  int          checks = 0;
  int          errors = 0;
  bit          model_en = 1'b0;

  // FIFO model: occupancy reflects a write one cycle later; rd drains one word.
  task automatic adv(input bit rd);
    int w;
    int n;
    w = ff.wr_en ? 1 : 0;
    @(posedge clk);
    #1;
    if (model_en) begin
      n = int'(ff.fifo_words) + w - (rd ? 1 : 0);
      ff.fifo_words = n[3:0];
    end
  endtask

  task automatic test_reset();
    ff.fifo_words = '0;
    ff.fifo_full  = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ff.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", ff.wr_en); end
    checks++; if (ff.fifo_data !== 8'hAA) begin errors++; $display("FAIL reset_data: got %h want aa", ff.fifo_data); end
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
    checks++; if (hi_evt !== 1'b0) begin errors++; $display("FAIL reset_hi_evt: got %b want 0", hi_evt); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_const_fill();
    int writes = 0;
    int his = 0;
    enable = 1'b1; mode = 1'b0; model_en = 1'b1; ff.fifo_words = '0;
    repeat (5) begin exp_q.push_back(8'hAA); exp_wc++; end
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (hi_evt === 1'b1) his++;
      if (ff.wr_en === 1'b1) begin
        writes++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL fill_extra_write: data=%h words=%0d, want no write", ff.fifo_data, ff.fifo_words);
        end else begin
          got = exp_q.pop_front();
          if (ff.fifo_data !== got) begin errors++; $display("FAIL fill_data: got %h want %h", ff.fifo_data, got); end
        end
      end
      adv(1'b0);
    end
    checks++; if (writes != 5) begin errors++; $display("FAIL fill_writes: got %0d want 5", writes); end
    checks++; if (his != 1) begin errors++; $display("FAIL fill_hi_evt: got %0d pulses want 1", his); end
    checks++; if (wr_count !== exp_wc) begin errors++; $display("FAIL fill_wr_count: got %0d want %0d", wr_count, exp_wc); end
    checks++; if (ff.fifo_words !== 4'd5) begin errors++; $display("FAIL fill_words: got %0d want 5", ff.fifo_words); end
  endtask

  task automatic test_hysteresis();
    bit seen2 = 1'b0;
    bit done = 1'b0;
    exp_q.push_back(8'hAA); exp_wc++;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      if (seen2) begin
        checks++;
        if (ff.wr_en !== 1'b1) begin
          errors++; $display("FAIL hyst_resume: wr_en got %b want 1", ff.wr_en);
        end else begin
          got = exp_q.pop_front();
          if (ff.fifo_data !== got) begin errors++; $display("FAIL hyst_data: got %h want %h", ff.fifo_data, got); end
        end
        done = 1'b1;
        adv(1'b0);
      end else begin
        if (ff.fifo_words <= 4'd4) begin
          checks++;
          if (ff.wr_en !== 1'b0) begin errors++; $display("FAIL hyst_hold: wr_en got %b want 0 at words %0d", ff.wr_en, ff.fifo_words); end
        end
        if (ff.fifo_words == 4'd2) seen2 = 1'b1;
        adv(ff.fifo_words > 4'd2);
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL hyst_timeout: resumed %b want 1", done); end
  endtask

  task automatic test_full_gate();
    mode = 1'b1; ff.fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (ff.wr_en !== 1'b0) begin errors++; $display("FAIL full_wr_en: got %b want 0", ff.wr_en); end
      checks++; if (wr_count !== exp_wc) begin errors++; $display("FAIL full_wr_count: got %0d want %0d", wr_count, exp_wc); end
      checks++; if (ff.fifo_data !== 8'hAA) begin errors++; $display("FAIL full_data: got %h want aa", ff.fifo_data); end
      adv(1'b0);
    end
    ff.fifo_full = 1'b0;
    exp_q.push_back(8'hAA); exp_wc++;
    @(negedge clk);
    checks++;
    if (ff.wr_en !== 1'b1) begin
      errors++; $display("FAIL full_resume: wr_en got %b want 1", ff.wr_en);
    end else begin
      got = exp_q.pop_front();
      if (ff.fifo_data !== got) begin errors++; $display("FAIL full_resume_data: got %h want %h", ff.fifo_data, got); end
    end
    adv(1'b0);
  endtask

  task automatic test_overshoot();
    int his = 0;
    model_en = 1'b0;
    ff.fifo_words = 4'd3;
    exp_q.push_back(8'hAB); exp_wc++;
    @(negedge clk);
    checks++;
    if (ff.wr_en !== 1'b1) begin
      errors++; $display("FAIL over_pre_write: wr_en got %b want 1", ff.wr_en);
    end else begin
      got = exp_q.pop_front();
      if (ff.fifo_data !== got) begin errors++; $display("FAIL over_incr_data: got %h want %h", ff.fifo_data, got); end
    end
    adv(1'b0);
    ff.fifo_words = 4'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (ff.wr_en !== 1'b0) begin errors++; $display("FAIL over_wr_en: got %b want 0 (cycle %0d)", ff.wr_en, i); end
      if (hi_evt === 1'b1) his++;
      adv(1'b0);
    end
    checks++; if (his != 1) begin errors++; $display("FAIL over_hi_evt: got %0d pulses want 1", his); end
  endtask

  task automatic test_incr_wrap();
    logic [7:0] v = 8'hAC;
    int n = 0;
    do begin exp_q.push_back(v); exp_wc++; v = v + 8'd1; end while (v != 8'h01);
    ff.fifo_words = 4'd0;
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      if (ff.wr_en === 1'b1) begin
        got = exp_q.pop_front();
        n++;
        checks++;
        if (ff.fifo_data !== got) begin errors++; $display("FAIL incr_data: got %h want %h", ff.fifo_data, got); end
      end
      adv(1'b0);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL incr_timeout: %0d writes seen, %0d missing", n, exp_q.size()); end
    mode = 1'b0; ff.fifo_words = 4'd7;
    @(negedge clk);
    checks++; if (ff.fifo_data !== 8'h01) begin errors++; $display("FAIL incr_after_wrap: got %h want 01", ff.fifo_data); end
    adv(1'b0);
    @(negedge clk);
    checks++; if (ff.fifo_data !== 8'hAA) begin errors++; $display("FAIL mode_reload: got %h want aa", ff.fifo_data); end
    checks++; if (wr_count !== exp_wc) begin errors++; $display("FAIL incr_wr_count: got %0d want %0d", wr_count, exp_wc); end
    adv(1'b0);
  endtask

  task automatic test_enable_low();
    enable = 1'b0; ff.fifo_words = 4'd0;
    @(negedge clk); adv(1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (ff.wr_en !== 1'b0) begin errors++; $display("FAIL idle_wr_en: got %b want 0", ff.wr_en); end
      adv(1'b0);
    end
    enable = 1'b1;
    exp_q.push_back(8'hAA); exp_wc++;
    @(negedge clk);
    checks++; if (ff.wr_en !== 1'b0) begin errors++; $display("FAIL start_latency: wr_en got %b want 0", ff.wr_en); end
    adv(1'b0);
    @(negedge clk);
    checks++;
    if (ff.wr_en !== 1'b1) begin
      errors++; $display("FAIL start_write: wr_en got %b want 1", ff.wr_en);
    end else begin
      got = exp_q.pop_front();
      if (ff.fifo_data !== got) begin errors++; $display("FAIL start_data: got %h want %h", ff.fifo_data, got); end
    end
    adv(1'b0);
    // High mark and disable in the same cycle: must land in IDLE, not WAIT.
    ff.fifo_words = 4'd5; enable = 1'b0;
    @(negedge clk);
    checks++; if (ff.wr_en !== 1'b0) begin errors++; $display("FAIL race_wr_en: got %b want 0", ff.wr_en); end
    adv(1'b0);
    enable = 1'b1; ff.fifo_words = 4'd3;
    @(negedge clk);
    checks++; if (hi_evt !== 1'b0) begin errors++; $display("FAIL race_hi_evt: got %b want 0", hi_evt); end
    checks++; if (ff.wr_en !== 1'b0) begin errors++; $display("FAIL race_idle: wr_en got %b want 0", ff.wr_en); end
    adv(1'b0);
    exp_q.push_back(8'hAA); exp_wc++;
    @(negedge clk);
    checks++;
    if (ff.wr_en !== 1'b1) begin
      errors++; $display("FAIL race_restart: wr_en got %b want 1", ff.wr_en);
    end else begin
      got = exp_q.pop_front();
      if (ff.fifo_data !== got) begin errors++; $display("FAIL race_data: got %h want %h", ff.fifo_data, got); end
    end
    checks++; if (wr_count !== exp_wc - 16'd1) begin errors++; $display("FAIL race_wr_count: got %0d want %0d", wr_count, exp_wc - 16'd1); end
  endtask

  // Entered at a falling edge with a write in progress.
  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ff.wr_en !== 1'b0) begin errors++; $display("FAIL areset_wr_en: got %b want 0", ff.wr_en); end
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL areset_wr_count: got %0d want 0", wr_count); end
    checks++; if (ff.fifo_data !== 8'hAA) begin errors++; $display("FAIL areset_data: got %h want aa", ff.fifo_data); end
    checks++; if (hi_evt !== 1'b0) begin errors++; $display("FAIL areset_hi_evt: got %b want 0", hi_evt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: %0d expected writes never seen", exp_q.size()); end
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_const_fill();
    test_hysteresis();
    test_full_gate();
    test_overshoot();
    test_incr_wrap();
    test_enable_low();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks done", checks);
    $fatal(1);
  end

endmodule
